// File: rtl/bsg_link_sdr_pkg.sv
// ---------------------------------------------------------------------------
// bsg_link_sdr_pkg
//   Shared definitions for the SDR link receive endpoint.
//   - ptr_width(): FIFO pointer width, which is one wrap bit more than the
//     address width, so that full and empty can be told apart.
//   - token_state_e: level of the returned credit token.
// ---------------------------------------------------------------------------
package bsg_link_sdr_pkg;

   function automatic int ptr_width(input int lg_depth);
      return lg_depth + 1;
   endfunction

   typedef enum logic {
      TOKEN_LOW  = 1'b0,
      TOKEN_HIGH = 1'b1
   } token_state_e;

endpackage

// File: rtl/bsg_link_sdr_rx_credit_counter.sv
// ---------------------------------------------------------------------------
// bsg_link_sdr_rx_credit_counter
//   Converts dequeues into credit-token edges. It toggles the token once for
//   every 2^lg_decim_p dequeues. The token is a flop output, so it cannot
//   glitch.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset; token and count go to 0
//   yumi_i     one dequeue this cycle
//   token_o    credit token level
// ---------------------------------------------------------------------------
module bsg_link_sdr_rx_credit_counter
   import bsg_link_sdr_pkg::*;
#(
   parameter int lg_decim_p = 0
)(
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic yumi_i,
   output logic token_o
);

   token_state_e token_q, token_d;
   logic         wrap;

   generate
      if (lg_decim_p == 0) begin : g_no_decim
         assign wrap = yumi_i;
      end else begin : g_decim
         logic [lg_decim_p-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (yumi_i) cnt_d = cnt_q + lg_decim_p'(1);
         end

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) cnt_q <= '0;
            else            cnt_q <= cnt_d;
         end

         // The counter is about to roll over to zero on this dequeue.
         assign wrap = yumi_i && (&cnt_q);
      end
   endgenerate

   always_comb begin
      token_d = token_q;
      if (wrap) token_d = (token_q == TOKEN_LOW) ? TOKEN_HIGH : TOKEN_LOW;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) token_q <= TOKEN_LOW;
      else            token_q <= token_d;
   end

   assign token_o = (token_q == TOKEN_HIGH);

endmodule

// File: rtl/bsg_link_sdr_rx_endpoint.sv
// ---------------------------------------------------------------------------
// bsg_link_sdr_rx_endpoint
//   Receive end of a credit-based SDR link, clocked by one local clock.
//   The incoming word is registered every cycle and has no backpressure. It
//   is then buffered in a 2^lg_fifo_depth_p entry FIFO and handed to the core
//   with a valid/yumi handshake. Dequeues return credits on link_token_o.
// Ports:
//   clk_i         clock
//   reset_n_i     asynchronous active-low reset
//   link_v_i      incoming word valid
//   link_data_i   incoming word
//   link_token_o  credit token; each edge returns 2^decimation credits
//   core_v_o      FIFO head valid
//   core_data_o   FIFO head word
//   core_yumi_i   core consumes the head (only while core_v_o=1)
//   overflow_o    sticky: a word arrived while the FIFO was full
//   rx_count_o    saturating count of accepted words
//                 (only with BSG_LINK_SDR_RX_STATS_EN)
// Configuration macro: BSG_LINK_SDR_RX_STATS_EN
// ---------------------------------------------------------------------------
module bsg_link_sdr_rx_endpoint
   import bsg_link_sdr_pkg::*;
#(
   parameter int width_p                         = 16,
   parameter int lg_fifo_depth_p                 = 3,
   parameter int lg_credit_to_token_decimation_p = 0,
   parameter int stats_width_p                   = 32
)(
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               link_v_i,
   input  logic [width_p-1:0] link_data_i,
   output logic               link_token_o,
   output logic               core_v_o,
   output logic [width_p-1:0] core_data_o,
   input  logic               core_yumi_i,
   output logic               overflow_o
`ifdef BSG_LINK_SDR_RX_STATS_EN
  ,output logic [stats_width_p-1:0] rx_count_o
`endif
);

   localparam int ptr_w_lp = ptr_width(lg_fifo_depth_p);
   localparam int depth_lp = 1 << lg_fifo_depth_p;

   logic                v_q;
   logic [width_p-1:0]  data_q;
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic                overflow_q, overflow_d;
   logic [width_p-1:0]  mem_q [depth_lp];
   logic                empty, full, enq, deq, drop;

   // Capture stage: link inputs are registered every cycle.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) v_q <= 1'b0;
      else            v_q <= link_v_i;
   end

   always_ff @(posedge clk_i) begin
      data_q <= link_data_i;
   end

   // FIFO stage: the extra MSB on each pointer separates full from empty.
   assign empty = (rd_ptr_q == wr_ptr_q);
   assign full  = (rd_ptr_q[ptr_w_lp-1] != wr_ptr_q[ptr_w_lp-1]) &&
                  (rd_ptr_q[ptr_w_lp-2:0] == wr_ptr_q[ptr_w_lp-2:0]);

   assign deq  = core_yumi_i && !empty;
   // At full, a dequeue in the same cycle frees the slot being written.
   assign enq  = v_q && (!full || deq);
   assign drop = v_q && full && !deq;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      if (deq)  rd_ptr_d   = rd_ptr_q + ptr_w_lp'(1);
      if (enq)  wr_ptr_d   = wr_ptr_q + ptr_w_lp'(1);
      if (drop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q[ptr_w_lp-2:0]] <= data_q;
   end

   assign core_v_o    = !empty;
   assign core_data_o = mem_q[rd_ptr_q[ptr_w_lp-2:0]];
   assign overflow_o  = overflow_q;

   bsg_link_sdr_rx_credit_counter #(
      .lg_decim_p(lg_credit_to_token_decimation_p)
   ) u_credit (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .yumi_i   (deq),
      .token_o  (link_token_o)
   );

`ifdef BSG_LINK_SDR_RX_STATS_EN
   logic [stats_width_p-1:0] rx_count_q, rx_count_d;

   always_comb begin
      rx_count_d = rx_count_q;
      if (enq && !(&rx_count_q)) rx_count_d = rx_count_q + stats_width_p'(1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rx_count_q <= '0;
      else            rx_count_q <= rx_count_d;
   end

   assign rx_count_o = rx_count_q;
`endif

   a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  core_yumi_i |-> core_v_o);

endmodule
